// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg
//   Shared definitions for the FPU issue control slice: the issue FSM state
//   type, the FPU op-code map (every FPU op has bit 4 set), and the largest
//   multicycle latency the issue logic will honour.
package fpu_ctrl_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } fpu_state_e;

  localparam logic [4:0] FADD   = 5'b10000;
  localparam logic [4:0] FSUB   = 5'b10001;
  localparam logic [4:0] FMUL   = 5'b10010;
  localparam logic [4:0] FDIV   = 5'b10011;
  localparam logic [4:0] FSQRT  = 5'b10100;
  localparam logic [4:0] FMIN   = 5'b10101;
  localparam logic [4:0] FMAX   = 5'b10110;
  localparam logic [4:0] FCVTSW = 5'b10111;
  localparam logic [4:0] FSGNJ  = 5'b11000;
  localparam logic [4:0] FSGNJN = 5'b11001;
  localparam logic [4:0] FSGNJX = 5'b11010;
  localparam logic [4:0] FEQ    = 5'b11011;
  localparam logic [4:0] FLT    = 5'b11100;
  localparam logic [4:0] FCVTWS = 5'b11101;

  localparam int MAX_LAT = 7;

  // Bit 4 of the decoded control code marks the op as belonging to the FPU.
  function automatic logic is_fpu_op(input logic [4:0] cont);
    return cont[4];
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// fpu_lat_counter
//   Down-counter tracking the remaining cycles of a multicycle FPU op.
//   Ports:
//     clk, rstn  : clock, asynchronous active-low reset
//     load       : load load_val (takes priority over clear)
//     load_val   : starting count, already saturated by the caller
//     clear      : abandon the current count
//     tc         : count equals 1 (final busy cycle)
//     gt1        : count is above 1 (more busy cycles follow this one)
module fpu_lat_counter
  import fpu_ctrl_pkg::*;
#(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             clear,
  output logic             tc,
  output logic             gt1
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  // The count parks at zero once exhausted so an idle counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc  = (cnt_q == LAT_W'(1));
  assign gt1 = (cnt_q > LAT_W'(1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Issues EX-stage FPU ops to the FPU datapath, stalls the front of the
//   pipeline for multicycle ops and produces a one-cycle writeback strobe.
//   Ports:
//     clk, rstn                : clock, asynchronous active-low reset
//     issue_valid/cont/lat     : EX instruction valid, control code, stall count
//     issue_x1/x2              : EX operands
//     issue_rd/issue_rd_float  : destination index and register file select
//     flush                    : kill the in-flight FPU op
//     fpu_y                    : FPU datapath result
//     fpu_x1/x2/cont           : operands and op select driven to the FPU
//     stall                    : freeze IF/ID/EX
//     busy                     : multicycle op in flight
//     wb_valid/rd/float/data   : writeback strobe and payload
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_valid,
  input  logic [4:0]       issue_cont,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic [31:0]      issue_x1,
  input  logic [31:0]      issue_x2,
  input  logic [4:0]       issue_rd,
  input  logic             issue_rd_float,
  input  logic             flush,
  input  logic [31:0]      fpu_y,
  output logic [31:0]      fpu_x1,
  output logic [31:0]      fpu_x2,
  output logic [4:0]       fpu_cont,
  output logic             stall,
  output logic             busy,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_float,
  output logic [31:0]      wb_data
);

  localparam logic [LAT_W-1:0] LAT_CAP = LAT_W'(MAX_LAT);

  fpu_state_e state_q, state_d;

  logic [31:0]      x1_q, x1_d, x2_q, x2_d;
  logic [4:0]       cont_q, cont_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_float_q, rd_float_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_float_q, wb_float_d;
  logic [31:0]      wb_data_q, wb_data_d;

  logic [LAT_W-1:0] lat_sat;
  logic             lat_zero;
  logic             accept;
  logic             in_busy;
  logic             busy_done;
  logic             cnt_tc;
  logic             cnt_gt1;
  logic             cnt_load;
  logic             cnt_clear;

  // Accept is gated by rstn so that a valid FPU op presented while reset is
  // held cannot raise stall combinationally.
  always_comb begin
    lat_sat   = (issue_lat > LAT_CAP) ? LAT_CAP : issue_lat;
    lat_zero  = (lat_sat == '0);
    in_busy   = (state_q == S_BUSY);
    accept    = rstn && !in_busy && issue_valid && is_fpu_op(issue_cont) && !flush;
    busy_done = in_busy && cnt_tc && !flush;
    cnt_load  = accept && !lat_zero;
    cnt_clear = in_busy && flush;
  end

  // Next state, operand holding and writeback capture. A zero-latency op
  // writes back straight from the accept edge; a multicycle op writes back
  // from its final busy cycle unless flushed.
  always_comb begin
    state_d    = state_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    cont_d     = cont_q;
    rd_d       = rd_q;
    rd_float_d = rd_float_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_float_d = wb_float_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept && !lat_zero) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush || cnt_tc) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      x1_d       = issue_x1;
      x2_d       = issue_x2;
      cont_d     = issue_cont;
      rd_d       = issue_rd;
      rd_float_d = issue_rd_float;
    end

    if (accept && lat_zero) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = issue_rd;
      wb_float_d = issue_rd_float;
      wb_data_d  = fpu_y;
    end else if (busy_done) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = rd_q;
      wb_float_d = rd_float_q;
      wb_data_d  = fpu_y;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      x1_q       <= '0;
      x2_q       <= '0;
      cont_q     <= '0;
      rd_q       <= '0;
      rd_float_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_float_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      cont_q     <= cont_d;
      rd_q       <= rd_d;
      rd_float_q <= rd_float_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_float_q <= wb_float_d;
      wb_data_q  <= wb_data_d;
    end
  end

  fpu_lat_counter #(
    .LAT_W(LAT_W)
  ) u_lat_counter (
    .clk     (clk),
    .rstn    (rstn),
    .load    (cnt_load),
    .load_val(lat_sat),
    .clear   (cnt_clear),
    .tc      (cnt_tc),
    .gt1     (cnt_gt1)
  );

  // The final busy cycle is left unstalled so the frozen instruction moves
  // on exactly once; a flush releases the pipeline in the same cycle.
  assign stall    = (accept && !lat_zero) || (in_busy && cnt_gt1 && !flush);
  assign busy     = in_busy;
  assign fpu_x1   = in_busy ? x1_q   : issue_x1;
  assign fpu_x2   = in_busy ? x2_q   : issue_x2;
  assign fpu_cont = in_busy ? cont_q : issue_cont;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_float = wb_float_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl
//   Self-checking bench for fpu_issue_ctrl: reset values, a table of
//   per-cycle vectors, hand-written multicycle sequences (flush, back-to-back,
//   latency saturation, reset mid-op) and a randomized run against a
//   transaction-level reference model.
module tb_fpu_issue_ctrl;
  import fpu_ctrl_pkg::*;

  logic        clk;
  logic        rstn;
  logic        issue_valid;
  logic [4:0]  issue_cont;
  logic [3:0]  issue_lat;
  logic [31:0] issue_x1, issue_x2;
  logic [4:0]  issue_rd;
  logic        issue_rd_float;
  logic        flush;
  logic [31:0] fpu_y;
  logic [31:0] fpu_x1, fpu_x2;
  logic [4:0]  fpu_cont;
  logic        stall, busy, wb_valid, wb_float;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  fpu_issue_ctrl #(.LAT_W(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .issue_valid   (issue_valid),
    .issue_cont    (issue_cont),
    .issue_lat     (issue_lat),
    .issue_x1      (issue_x1),
    .issue_x2      (issue_x2),
    .issue_rd      (issue_rd),
    .issue_rd_float(issue_rd_float),
    .flush         (flush),
    .fpu_y         (fpu_y),
    .fpu_x1        (fpu_x1),
    .fpu_x2        (fpu_x2),
    .fpu_cont      (fpu_cont),
    .stall         (stall),
    .busy          (busy),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_float      (wb_float),
    .wb_data       (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic v; logic [4:0] cont; logic [3:0] lat; logic fl;
    logic [31:0] x1; logic [4:0] rd; logic rdf; logic [31:0] y;
    logic e_stall; logic e_busy; logic e_wbv; logic [31:0] e_wbd;
    logic [4:0] e_wbrd; logic e_wbf; logic [4:0] e_fcont; logic [31:0] e_fx1;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mkv(input logic v, input logic [4:0] cont, input logic [3:0] lat,
                               input logic fl, input logic [31:0] x1, input logic [4:0] rd,
                               input logic rdf, input logic [31:0] y, input logic e_stall,
                               input logic e_busy, input logic e_wbv, input logic [31:0] e_wbd,
                               input logic [4:0] e_wbrd, input logic e_wbf,
                               input logic [4:0] e_fcont, input logic [31:0] e_fx1);
    vec_t r;
    r.v = v; r.cont = cont; r.lat = lat; r.fl = fl; r.x1 = x1; r.rd = rd; r.rdf = rdf;
    r.y = y; r.e_stall = e_stall; r.e_busy = e_busy; r.e_wbv = e_wbv; r.e_wbd = e_wbd;
    r.e_wbrd = e_wbrd; r.e_wbf = e_wbf; r.e_fcont = e_fcont; r.e_fx1 = e_fx1;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [4:0] cont, input logic [3:0] lat,
                                input logic fl, input logic [31:0] x1, input logic [31:0] x2,
                                input logic [4:0] rd, input logic rdf, input logic [31:0] y);
    issue_valid = v; issue_cont = cont; issue_lat = lat; flush = fl;
    issue_x1 = x1; issue_x2 = x2; issue_rd = rd; issue_rd_float = rdf; fpu_y = y;
  endtask

  task automatic idle_inputs(input logic [31:0] y);
    apply_stimulus(1'b0, 5'b00000, 4'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, y);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles after an accept edge until wb_valid is seen; 0 if never.
  task automatic wait_wb(input int bound, output int found);
    found = 0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        found = k;
        break;
      end
      next_edge();
    end
  endtask

  // ---------------- reference model (random phase) ----------------
  int          m_cyc;
  bit          m_busy;
  int          m_acc_cyc, m_n;
  logic [31:0] m_x1, m_x2;
  logic [4:0]  m_cont, m_rd;
  logic        m_rdf;
  logic        e_wbv;
  logic [31:0] e_wbd;
  logic [4:0]  e_wbrd;
  logic        e_wbf;

  task automatic model_reset();
    m_cyc = 0; m_busy = 0; m_acc_cyc = 0; m_n = 0;
    m_x1 = '0; m_x2 = '0; m_cont = '0; m_rd = '0; m_rdf = 1'b0;
    e_wbv = 1'b0; e_wbd = '0; e_wbrd = '0; e_wbf = 1'b0;
  endtask

  function automatic int eff_lat();
    return (int'(issue_lat) > MAX_LAT) ? MAX_LAT : int'(issue_lat);
  endfunction

  function automatic bit model_accepts();
    return !m_busy && issue_valid && issue_cont[4] && !flush;
  endfunction

  task automatic model_compare();
    bit   acc;
    logic e_stall;
    acc = model_accepts();
    e_stall = (acc && eff_lat() > 0) || (m_busy && !flush && m_cyc < m_acc_cyc + m_n);
    check_output("rnd_stall",    stall,    e_stall);
    check_output("rnd_busy",     busy,     m_busy);
    check_output("rnd_wb_valid", wb_valid, e_wbv);
    check_output("rnd_wb_data",  wb_data,  e_wbd);
    check_output("rnd_wb_rd",    wb_rd,    e_wbrd);
    check_output("rnd_wb_float", wb_float, e_wbf);
    check_output("rnd_fpu_cont", fpu_cont, m_busy ? m_cont : issue_cont);
    check_output("rnd_fpu_x1",   fpu_x1,   m_busy ? m_x1 : issue_x1);
    check_output("rnd_fpu_x2",   fpu_x2,   m_busy ? m_x2 : issue_x2);
  endtask

  task automatic model_edge();
    bit acc, last;
    int n;
    acc  = model_accepts();
    n    = eff_lat();
    last = m_busy && (m_cyc == m_acc_cyc + m_n);
    e_wbv = 1'b0;
    if (acc && n == 0) begin
      e_wbv = 1'b1; e_wbd = fpu_y; e_wbrd = issue_rd; e_wbf = issue_rd_float;
    end
    if (last && !flush) begin
      e_wbv = 1'b1; e_wbd = fpu_y; e_wbrd = m_rd; e_wbf = m_rdf;
    end
    if (m_busy && (flush || last)) m_busy = 0;
    if (acc) begin
      m_x1 = issue_x1; m_x2 = issue_x2; m_cont = issue_cont; m_rd = issue_rd; m_rdf = issue_rd_float;
      if (n > 0) begin
        m_busy = 1; m_acc_cyc = m_cyc; m_n = n;
      end
    end
    m_cyc++;
  endtask

  initial begin
    int found;
    bit saw_wbv, saw_busy;

    // ---------------- reset ----------------
    rstn = 1'b0;
    apply_stimulus(1'b1, FADD, 4'd3, 1'b0, 32'h1, 32'h2, 5'd1, 1'b1, 32'h99);
    next_edge();
    next_edge();
    check_output("rst_stall",    stall,    1'b0);
    check_output("rst_busy",     busy,     1'b0);
    check_output("rst_wb_valid", wb_valid, 1'b0);
    check_output("rst_wb_rd",    wb_rd,    5'd0);
    check_output("rst_wb_float", wb_float, 1'b0);
    check_output("rst_wb_data",  wb_data,  32'h0);
    idle_inputs(32'h0);
    @(negedge clk);
    rstn = 1'b1;
    next_edge();

    // ---------------- table-driven vectors ----------------
    tbl[0]  = mkv(1, FADD,     4'd5, 0, 32'h3F800000, 5'd3, 1, 32'h0,       1, 0, 0, 32'h0,       5'd0, 0, FADD,     32'h3F800000);
    tbl[1]  = mkv(1, FMUL,     4'd2, 0, 32'hDEADBEEF, 5'd9, 0, 32'h11111111, 1, 1, 0, 32'h0,       5'd0, 0, FADD,     32'h3F800000);
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = tbl[1];
    tbl[5]  = mkv(1, FMUL,     4'd2, 0, 32'hDEADBEEF, 5'd9, 0, 32'h40400000, 0, 1, 0, 32'h0,       5'd0, 0, FADD,     32'h3F800000);
    tbl[6]  = mkv(1, 5'b00000, 4'd3, 0, 32'h12345678, 5'd4, 0, 32'h0,       0, 0, 1, 32'h40400000, 5'd3, 1, 5'b00000, 32'h12345678);
    tbl[7]  = mkv(1, 5'b00001, 4'd2, 0, 32'h87654321, 5'd4, 0, 32'h0,       0, 0, 0, 32'h40400000, 5'd3, 1, 5'b00001, 32'h87654321);
    tbl[8]  = mkv(1, FSGNJ,    4'd0, 0, 32'h0000AAAA, 5'd5, 1, 32'hAAAA0001, 0, 0, 0, 32'h40400000, 5'd3, 1, FSGNJ,    32'h0000AAAA);
    tbl[9]  = mkv(1, FSGNJ,    4'd0, 0, 32'h0000BBBB, 5'd6, 0, 32'hBBBB0002, 0, 0, 1, 32'hAAAA0001, 5'd5, 1, FSGNJ,    32'h0000BBBB);
    tbl[10] = mkv(0, 5'b00000, 4'd0, 0, 32'h0,        5'd0, 0, 32'hCCCC0003, 0, 0, 1, 32'hBBBB0002, 5'd6, 0, 5'b00000, 32'h0);
    tbl[11] = mkv(0, 5'b00000, 4'd0, 0, 32'h0,        5'd0, 0, 32'hCCCC0003, 0, 0, 0, 32'hBBBB0002, 5'd6, 0, 5'b00000, 32'h0);
    tbl[12] = mkv(1, FADD,     4'd0, 1, 32'h0F0F0F0F, 5'd7, 1, 32'hDDDD0004, 0, 0, 0, 32'hBBBB0002, 5'd6, 0, FADD,     32'h0F0F0F0F);
    tbl[13] = mkv(0, 5'b00000, 4'd0, 0, 32'h0,        5'd0, 0, 32'h0,        0, 0, 0, 32'hBBBB0002, 5'd6, 0, 5'b00000, 32'h0);

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(tbl[i].v, tbl[i].cont, tbl[i].lat, tbl[i].fl, tbl[i].x1,
                     (i == 0) ? 32'h40000000 : 32'h0, tbl[i].rd, tbl[i].rdf, tbl[i].y);
      @(negedge clk);
      check_output($sformatf("tbl%0d_stall", i),    stall,    tbl[i].e_stall);
      check_output($sformatf("tbl%0d_busy", i),     busy,     tbl[i].e_busy);
      check_output($sformatf("tbl%0d_wb_valid", i), wb_valid, tbl[i].e_wbv);
      check_output($sformatf("tbl%0d_wb_data", i),  wb_data,  tbl[i].e_wbd);
      check_output($sformatf("tbl%0d_wb_rd", i),    wb_rd,    tbl[i].e_wbrd);
      check_output($sformatf("tbl%0d_wb_float", i), wb_float, tbl[i].e_wbf);
      check_output($sformatf("tbl%0d_fpu_cont", i), fpu_cont, tbl[i].e_fcont);
      check_output($sformatf("tbl%0d_fpu_x1", i),   fpu_x1,   tbl[i].e_fx1);
      next_edge();
    end

    // ---------------- fdiv lat=7 flushed in third busy cycle ----------------
    apply_stimulus(1'b1, FDIV, 4'd7, 1'b0, 32'h1, 32'h2, 5'd1, 1'b1, 32'hE0E0E0E0);
    @(negedge clk);
    check_output("fdiv_accept_stall", stall, 1'b1);
    next_edge();
    idle_inputs(32'hE1E1E1E1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check_output($sformatf("fdiv_busy%0d_stall", k), stall, 1'b1);
      next_edge();
    end
    apply_stimulus(1'b0, 5'b00000, 4'd0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 32'hE2E2E2E2);
    @(negedge clk);
    check_output("fdiv_flush_stall", stall, 1'b0);
    check_output("fdiv_flush_busy",  busy,  1'b1);
    next_edge();
    idle_inputs(32'hE3E3E3E3);
    @(negedge clk);
    check_output("fdiv_after_flush_busy", busy, 1'b0);
    saw_wbv = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) saw_wbv = 1;
      next_edge();
    end
    check_output("fdiv_no_wb", saw_wbv, 1'b0);

    // ---------------- flush coinciding with final busy cycle ----------------
    apply_stimulus(1'b1, FMUL, 4'd2, 1'b0, 32'h3, 32'h4, 5'd2, 1'b1, 32'hF0);
    next_edge();
    idle_inputs(32'hF1);
    next_edge();
    apply_stimulus(1'b0, 5'b00000, 4'd0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 32'hF2);
    @(negedge clk);
    check_output("tc_flush_stall", stall, 1'b0);
    next_edge();
    idle_inputs(32'hF3);
    saw_wbv = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) saw_wbv = 1;
      next_edge();
    end
    check_output("tc_flush_no_wb", saw_wbv, 1'b0);
    check_output("tc_flush_busy",  busy,    1'b0);

    // ---------------- fcvtws lat=2 then fmul back-to-back ----------------
    apply_stimulus(1'b1, FCVTWS, 4'd2, 1'b0, 32'h41200000, 32'h0, 5'd10, 1'b0, 32'h0);
    @(negedge clk);
    check_output("cvt_accept_stall", stall, 1'b1);
    next_edge();
    apply_stimulus(1'b1, FMUL, 4'd5, 1'b0, 32'h40000000, 32'h40400000, 5'd12, 1'b1, 32'h1);
    @(negedge clk);
    check_output("cvt_busy1_stall", stall, 1'b1);
    next_edge();
    fpu_y = 32'h0000000A;
    @(negedge clk);
    check_output("cvt_busy2_stall", stall, 1'b0);
    check_output("cvt_busy2_busy",  busy,  1'b1);
    next_edge();
    fpu_y = 32'h2;
    @(negedge clk);
    check_output("cvt_wb_valid",   wb_valid, 1'b1);
    check_output("cvt_wb_rd",      wb_rd,    5'd10);
    check_output("cvt_wb_float",   wb_float, 1'b0);
    check_output("cvt_wb_data",    wb_data,  32'h0000000A);
    check_output("fmul_acc_stall", stall,    1'b1);
    next_edge();
    idle_inputs(32'h40C00000);
    wait_wb(15, found);
    check_output("fmul_wb_cycle", found,    6);
    check_output("fmul_wb_rd",    wb_rd,    5'd12);
    check_output("fmul_wb_float", wb_float, 1'b1);
    check_output("fmul_wb_data",  wb_data,  32'h40C00000);
    next_edge();

    // ---------------- latency above 7 saturates ----------------
    apply_stimulus(1'b1, FSQRT, 4'd15, 1'b0, 32'h5, 32'h6, 5'd2, 1'b1, 32'h0);
    next_edge();
    idle_inputs(32'h00000077);
    wait_wb(20, found);
    check_output("sat_wb_cycle", found, 8);
    next_edge();

    // ---------------- reset mid-busy at cnt=3 ----------------
    apply_stimulus(1'b1, FDIV, 4'd6, 1'b0, 32'h7, 32'h8, 5'd4, 1'b1, 32'h0);
    next_edge();
    idle_inputs(32'h0000ABCD);
    for (int k = 0; k < 3; k++) next_edge();
    rstn = 1'b0;
    #1;
    check_output("rstmid_stall",    stall,    1'b0);
    check_output("rstmid_busy",     busy,     1'b0);
    check_output("rstmid_wb_valid", wb_valid, 1'b0);
    check_output("rstmid_wb_rd",    wb_rd,    5'd0);
    check_output("rstmid_wb_float", wb_float, 1'b0);
    check_output("rstmid_wb_data",  wb_data,  32'h0);
    next_edge();
    next_edge();
    @(negedge clk);
    rstn = 1'b1;
    next_edge();
    saw_wbv = 0;
    saw_busy = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) saw_wbv = 1;
      if (busy === 1'b1) saw_busy = 1;
      next_edge();
    end
    check_output("rstmid_no_wb",   saw_wbv,  1'b0);
    check_output("rstmid_no_busy", saw_busy, 1'b0);

    // ---------------- randomized run against the reference model ----------------
    rstn = 1'b0;
    idle_inputs(32'h0);
    next_edge();
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    next_edge();
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                     5'($urandom),
                     ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                     $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom);
      @(negedge clk);
      model_compare();
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT_W, default 4, width of the latency input and counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 issue_valid  input  1  the EX-stage instruction is valid this cycle.
REQ-005 issue_cont  input  5  decoded ALU/FPU control code; bit 4 set means an FPU op.
REQ-006 issue_lat  input  LAT_W  FPU stall count from the decoder (0..7).
REQ-007 issue_x1, issue_x2  input  32 each  EX-stage FPU operands.
REQ-008 issue_rd  input  5  destination register index.
REQ-009 issue_rd_float  input  1  destination is the float register file.
REQ-010 flush  input  1  kill the in-flight FPU op (branch or jump redirect).
REQ-011 fpu_y  input  32  result returned by the FPU datapath.
REQ-012 fpu_x1, fpu_x2  output  32 each  operands driven to the FPU.
REQ-013 fpu_cont  output  5  op select driven to the FPU.
REQ-014 stall  output  1  freeze IF/ID/EX.
REQ-015 busy  output  1  multicycle op in flight.
REQ-016 wb_valid  output  1  one-cycle writeback strobe.
REQ-017 wb_rd  output  5  writeback register index.
REQ-018 wb_float  output  1  writeback register file select.
REQ-019 wb_data  output  32  writeback data.

Function
REQ-020 SHALL implement the states IDLE and BUSY.
REQ-021 An accept happens in IDLE when issue_valid=1, issue_cont[4]=1 and flush=0; any other IDLE cycle SHALL NOT accept.
REQ-022 In IDLE, fpu_x1, fpu_x2 and fpu_cont SHALL pass issue_x1, issue_x2 and issue_cont through combinationally.
REQ-023 In BUSY, fpu_x1, fpu_x2 and fpu_cont SHALL be driven from registers latched at accept.
REQ-024 On accept with N=issue_lat:
  - issue_rd and issue_rd_float SHALL be latched.
  - If N=0: stay IDLE and capture fpu_y into wb_data at that edge.
  - If N>0: enter BUSY with counter cnt=N.
REQ-025 In BUSY, cnt SHALL decrement each cycle.
REQ-026 In the BUSY cycle with cnt=1: capture fpu_y into wb_data and return to IDLE at the edge.
REQ-027 stall SHALL equal (accept AND N>0) OR (BUSY AND cnt>1), combinationally.
  - The final BUSY cycle is unstalled, so the frozen instruction retires exactly once.
  - issue_valid seen during BUSY SHALL be ignored.
REQ-028 wb_valid SHALL pulse exactly N+1 cycles after the accept cycle, for one cycle.
  - wb_rd and wb_float are valid only with wb_valid.
  - wb_data, wb_rd and wb_float SHALL hold their values otherwise.
REQ-029 busy SHALL be 1 exactly while in BUSY.
REQ-030 Back-to-back: an accept in the same cycle that wb_valid is high SHALL be legal.
REQ-031 flush in BUSY SHALL force IDLE at the next edge, drop stall in that same cycle and suppress wb_valid.
REQ-032 flush coinciding with the cnt=1 capture cycle SHALL also suppress wb_valid.
REQ-033 An issue_lat value above 7 SHALL be treated as 7.

Reset
REQ-034 While rstn=0: state=IDLE, cnt=0, held operands=0, fpu_cont register=0.
REQ-035 While rstn=0: stall=0, busy=0, wb_valid=0, wb_rd=0, wb_float=0, wb_data=0.
REQ-036 Reset asserted mid-BUSY SHALL abort the op; no wb_valid SHALL follow reset release.

Structure
REQ-037 The shared package fpu_ctrl_pkg SHALL hold:
  - the state enum;
  - FPU op-code constants (FADD 10000 through FCVTWS 11101);
  - MAX_LAT=7.
REQ-038 The down-counter plus its terminal-count flag SHALL be the sub-module fpu_lat_counter; all else stays in one module.

Verification
REQ-039 Directed scenario: fadd (cont=10000, lat=5, x1=0x3F800000, x2=0x40000000), fpu_y model = 0x40400000 at the fifth BUSY cycle.
  - Required: stall high 5 cycles, wb_valid at accept+6, wb_data=0x40400000, wb_float=1.
REQ-040 Directed scenario: fsgnj (cont=11000, lat=0).
  - Required: stall never asserted, wb_valid at accept+1.
  - A second fsgnj on the next cycle gives wb_valid on consecutive cycles.
REQ-041 Directed scenario: fdiv (lat=7) with flush at the third BUSY cycle.
  - Required: stall drops that cycle, no wb_valid, busy=0 next cycle.
REQ-042 Directed scenario: fcvtws (cont=11101, lat=2, rd_float=0, rd=10), followed immediately by fmul (lat=5).
  - Required: wb_rd=10 and wb_float=0 at accept+3.
  - fmul accepted the cycle after the first op's final BUSY cycle.
REQ-043 Directed scenario: integer add (cont=00000, issue_valid=1).
  - Required: no accept, stall=0, wb_valid=0.
REQ-044 Directed scenario: rstn pulsed low during BUSY cnt=3.
  - Required: all outputs 0 immediately, no wb_valid after release.
